mux_arb_nx1: RTL and testbench
==============================

MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data channel, legal range 1..64.
REQ-002 Parameter NUM_CH, default 4: number of input channels, legal range 2..16.
REQ-003 Derived constant SEL_W SHALL equal ceil(log2(NUM_CH)).
REQ-004 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port RST, input, 1: asynchronous, active-high reset.
REQ-006 Port IN_DATA, input, NUM_CH*DATA_WIDTH: concatenated channel data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 Port IN_VALID, input, NUM_CH: per-channel valid.
REQ-008 Port IN_READY, output, NUM_CH: per-channel ready, combinational.
REQ-009 Port OUT_DATA, output, DATA_WIDTH: registered selected data.
REQ-010 Port OUT_VALID, output, 1: OUT_DATA holds an undelivered word.
REQ-011 Port OUT_READY, input, 1: downstream accepts the word.
REQ-012 Port OUT_SEL, output, SEL_W: index of the channel that supplied OUT_DATA.

Function
REQ-013 A transfer on channel k SHALL occur in a cycle where IN_VALID[k] and IN_READY[k] are both 1; an output transfer SHALL occur where OUT_VALID and OUT_READY are both 1.
REQ-014 Accept condition: OUT_VALID==0, or OUT_VALID==1 with OUT_READY==1 in the same cycle.
REQ-015 At most one IN_READY bit SHALL be 1 per cycle: the bit of the granted channel, and only when the accept condition holds and that channel is valid.
REQ-016 IN_READY SHALL not depend on the IN_VALID of non-granted channels in any way that creates a combinational loop; all IN_READY bits SHALL be 0 while RST is 1.
REQ-017 On an input transfer from channel k, the next edge SHALL load OUT_DATA with channel k data, set OUT_SEL to k and set OUT_VALID to 1; latency is exactly one cycle.
REQ-018 If an output transfer occurs with no input transfer, OUT_VALID SHALL clear to 0; OUT_DATA and OUT_SEL SHALL keep their last values.
REQ-019 While OUT_VALID==1 and OUT_READY==0, OUT_DATA, OUT_SEL and OUT_VALID SHALL hold stable.
REQ-020 Simultaneous output drain and input accept SHALL sustain one word per cycle with no bubble.
REQ-021 With no IN_VALID bit set, no grant SHALL be issued and the priority state SHALL be unchanged.
REQ-022 Data bits SHALL pass unmodified; there is no width conversion.

Reset
REQ-023 When RST is asserted, OUT_VALID=0, OUT_DATA=0 and OUT_SEL=0 SHALL take effect immediately, independent of CLK.
REQ-024 The round-robin pointer SHALL reset so that channel 0 has highest priority.
REQ-025 A word held in the output register when reset is asserted SHALL be discarded, and no IN_READY bit SHALL be asserted until the first edge after RST deasserts.

Configuration
REQ-026 Macro MUX_ARB_RR_EN SHALL select the arbitration policy at compile time.
REQ-027 With MUX_ARB_RR_EN defined: round-robin; after a grant to k, highest priority moves to (k+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
REQ-028 Without MUX_ARB_RR_EN: fixed priority with the lowest valid index winning; no pointer register is synthesized.

Structure
REQ-029 Package mux_arb_pkg SHALL hold the clog2 function, the DATA_WIDTH/NUM_CH defaults and the legal-range constants.
REQ-030 Grant logic SHALL live in the sub-module rr_arbiter (inputs: request vector, advance strobe; output: one-hot grant), instantiated once; the top level holds the output register and handshake.

Verification
REQ-031 The bench SHALL cover: NUM_CH=4, only channel 2 valid with data 0xDEADBEEF, OUT_READY=1 -> IN_READY=0100, and the next cycle gives OUT_DATA=0xDEADBEEF, OUT_SEL=2, OUT_VALID=1.
REQ-032 The bench SHALL cover: MUX_ARB_RR_EN defined, all four channels valid continuously, OUT_READY=1 -> OUT_SEL sequence 0,1,2,3,0 on consecutive cycles with no bubble.
REQ-033 The bench SHALL cover: MUX_ARB_RR_EN undefined, channels 1 and 3 valid continuously -> OUT_SEL is 1 on every cycle and channel 3 is never granted.
REQ-034 The bench SHALL cover: OUT_VALID=1 and OUT_READY held 0 for 5 cycles -> OUT_DATA and OUT_SEL are stable and all IN_READY bits are 0; OUT_READY is then raised and the held word transfers in that cycle.
REQ-035 The bench SHALL cover: RST pulsed between clock edges while OUT_VALID=1 -> OUT_VALID=0 and OUT_DATA=0 immediately; after release, the first grant goes to channel 0 when all channels are valid.
REQ-036 The bench SHALL cover: a random valid/ready scoreboard run of 10k cycles with DATA_WIDTH=8 and NUM_CH=3 -> no word is lost or duplicated and per-channel order is preserved.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the N:1 arbitrated multiplexer.
// Holds the parameter defaults, their legal ranges and a clog2 helper.
package mux_arb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_MIN = 1;
  localparam int DATA_WIDTH_MAX = 64;

  localparam int NUM_CH_DEF = 4;
  localparam int NUM_CH_MIN = 2;
  localparam int NUM_CH_MAX = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nx1_rr_arbiter.sv
// One-hot grant generator. Define MUX_ARB_RR_EN for round-robin priority;
// otherwise the lowest requesting index always wins and no pointer exists.
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  localparam int SEL_W = clog2(NUM_CH);

  function automatic logic [NUM_CH-1:0] lowest(input logic [NUM_CH-1:0] v);
    logic [NUM_CH-1:0] g;
    logic              found;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i] && !found) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  gidx;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] masked;

  // Requests at or above the pointer go first; fall back to the full vector.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    grant  = (|masked) ? lowest(masked) : lowest(req);
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) begin
        gidx = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && (|req)) begin
      ptr <= (gidx == SEL_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
    end
  end
`else
  logic unused_ok;

  assign grant     = lowest(req);
  assign unused_ok = ^{clk, rst, advance};
`endif

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 arbitrated mux with a one-word registered output stage and
// valid/ready handshakes. Policy selected by macro MUX_ARB_RR_EN.
module mux_arb_nx1
  import mux_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int NUM_CH     = NUM_CH_DEF,
  localparam int SEL_W      = clog2(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] IN_DATA,
  input  logic [NUM_CH-1:0]            IN_VALID,
  output logic [NUM_CH-1:0]            IN_READY,
  output logic [DATA_WIDTH-1:0]        OUT_DATA,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [SEL_W-1:0]             OUT_SEL
);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_param_check
    $error("mux_arb_nx1: DATA_WIDTH or NUM_CH out of legal range");
  end

  logic [NUM_CH-1:0]     grant;
  logic                  accept;
  logic                  take;
  logic                  ready_en;
  logic [DATA_WIDTH-1:0] sel_data_p0;
  logic [SEL_W-1:0]      sel_idx_p0;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [SEL_W-1:0]      sel_p1;
  logic                  vld_p1;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     (IN_VALID),
    .advance (take),
    .grant   (grant)
  );

  // ready_en keeps every IN_READY low until the first edge after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign accept   = ~vld_p1 | OUT_READY;
  assign take     = ready_en & accept & (|IN_VALID);
  assign IN_READY = take ? grant : '0;

  // Stage p0: select the granted channel.
  always_comb begin
    sel_data_p0 = '0;
    sel_idx_p0  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant[k]) begin
        sel_data_p0 = IN_DATA[k*DATA_WIDTH +: DATA_WIDTH];
        sel_idx_p0  = SEL_W'(k);
      end
    end
  end

  // Stage p1: output register, loaded on an input transfer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_p1 <= '0;
      sel_p1  <= '0;
      vld_p1  <= 1'b0;
    end else if (take) begin
      data_p1 <= sel_data_p0;
      sel_p1  <= sel_idx_p0;
      vld_p1  <= 1'b1;
    end else if (OUT_READY) begin
      vld_p1  <= 1'b0;
    end
  end

  assign OUT_DATA  = data_p1;
  assign OUT_SEL   = sel_p1;
  assign OUT_VALID = vld_p1;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Bench for mux_arb_nx1: directed handshake/arbitration scenarios on a 4x32
// instance and a random scoreboard run on a 3x8 instance.
module tb_mux_arb_nx1;

  localparam int DW  = 32;
  localparam int NC  = 4;
  localparam int SW  = 2;
  localparam int DW2 = 8;
  localparam int NC2 = 3;
  localparam int SW2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC*DW-1:0]  in_data;
  logic [NC-1:0]     in_valid;
  logic [NC-1:0]     in_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_sel;

  logic [NC2*DW2-1:0] r_in_data;
  logic [NC2-1:0]     r_in_valid;
  logic [NC2-1:0]     r_in_ready;
  logic [DW2-1:0]     r_out_data;
  logic               r_out_valid;
  logic               r_out_ready;
  logic [SW2-1:0]     r_out_sel;

  int n_pass  = 0;
  int n_total = 0;

  int         exp_sel_q[$];
  logic [7:0] sb_q[NC2][$];

  mux_arb_nx1 #(.DATA_WIDTH(DW), .NUM_CH(NC)) u_dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .OUT_DATA(out_data), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_SEL(out_sel)
  );

  mux_arb_nx1 #(.DATA_WIDTH(DW2), .NUM_CH(NC2)) u_sb (
    .CLK(clk), .RST(rst), .IN_DATA(r_in_data), .IN_VALID(r_in_valid),
    .IN_READY(r_in_ready), .OUT_DATA(r_out_data), .OUT_VALID(r_out_valid),
    .OUT_READY(r_out_ready), .OUT_SEL(r_out_sel)
  );

  task automatic set_ch(input int k, input logic [DW-1:0] v);
    in_data[k*DW +: DW] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    r_in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    in_valid = '1; out_ready = 1'b1;
    r_in_valid = '1; r_out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL reset_data: got %0h expected 0", out_data); else n_pass++;
    n_total++; if (out_sel !== '0) $display("FAIL reset_sel: got %0d expected 0", out_sel); else n_pass++;
    n_total++; if (in_ready !== 4'b0000) $display("FAIL reset_ready: got %b expected 0000", in_ready); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 4'b0000) $display("FAIL reset_release_ready: got %b expected 0000", in_ready); else n_pass++;
    in_valid = '0; r_in_valid = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_single_ch2();
    set_ch(0, 32'h1111_1111); set_ch(1, 32'h2222_2222);
    set_ch(2, 32'hDEAD_BEEF); set_ch(3, 32'h4444_4444);
    in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 4'b0100) $display("FAIL ch2_ready: got %b expected 0100", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_data !== 32'hDEAD_BEEF) $display("FAIL ch2_data: got %0h expected deadbeef", out_data); else n_pass++;
    n_total++; if (out_sel !== 2'd2) $display("FAIL ch2_sel: got %0d expected 2", out_sel); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL ch2_valid: got %0b expected 1", out_valid); else n_pass++;
    in_valid = '0;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 32'hDEAD_BEEF) $display("FAIL drain_keep_data: got %0h expected deadbeef", out_data); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_rr();
    int e;
    do_reset();
    for (int k = 0; k < NC; k++) set_ch(k, 32'h1000_0000 + k);
    exp_sel_q = {0, 1, 2, 3, 0};
    in_valid = 4'b1111; out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      e = exp_sel_q.pop_front();
      n_total++; if (out_valid !== 1'b1) $display("FAIL rr_valid: got %0b expected 1", out_valid); else n_pass++;
      n_total++; if (out_sel !== SW'(e)) $display("FAIL rr_sel: got %0d expected %0d", out_sel, e); else n_pass++;
      n_total++; if (out_data !== 32'h1000_0000 + e) $display("FAIL rr_data: got %0h expected %0h", out_data, 32'h1000_0000 + e); else n_pass++;
    end
    in_valid = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_fixed();
    do_reset();
    for (int k = 0; k < NC; k++) set_ch(k, 32'h3000_0000 + k);
    in_valid = 4'b1010; out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 4'b0010) $display("FAIL fixed_ready0: got %b expected 0010", in_ready); else n_pass++;
    repeat (8) begin
      @(posedge clk); #1;
      n_total++; if (out_valid !== 1'b1) $display("FAIL fixed_valid: got %0b expected 1", out_valid); else n_pass++;
      n_total++; if (out_sel !== 2'd1) $display("FAIL fixed_sel: got %0d expected 1", out_sel); else n_pass++;
      n_total++; if (in_ready !== 4'b0010) $display("FAIL fixed_ready: got %b expected 0010", in_ready); else n_pass++;
    end
    in_valid = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_hold();
    set_ch(1, 32'hA5A5_0001);
    in_valid = 4'b0010; out_ready = 1'b0;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) $display("FAIL hold_load: got %0b/%0h expected 1/a5a50001", out_valid, out_data); else n_pass++;
    for (int k = 0; k < NC; k++) set_ch(k, 32'h5A5A_0000 + k);
    in_valid = 4'b1111;
    #1;
    n_total++; if (in_ready !== 4'b0000) $display("FAIL hold_ready0: got %b expected 0000", in_ready); else n_pass++;
    repeat (5) begin
      @(posedge clk); #1;
      n_total++; if (out_data !== 32'hA5A5_0001) $display("FAIL hold_data: got %0h expected a5a50001", out_data); else n_pass++;
      n_total++; if (out_sel !== 2'd1) $display("FAIL hold_sel: got %0d expected 1", out_sel); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL hold_valid: got %0b expected 1", out_valid); else n_pass++;
      n_total++; if (in_ready !== 4'b0000) $display("FAIL hold_ready: got %b expected 0000", in_ready); else n_pass++;
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = '0;
    #1;
    n_total++; if (out_valid !== 1'b1) $display("FAIL hold_xfer: got %0b expected 1", out_valid); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL hold_after_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_data !== 32'hA5A5_0001 || out_sel !== 2'd1) $display("FAIL hold_after_keep: got %0h/%0d expected a5a50001/1", out_data, out_sel); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_async();
    set_ch(3, 32'hCAFE_F00D);
    in_valid = 4'b1000; out_ready = 1'b0;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b1 || out_sel !== 2'd3) $display("FAIL arst_pre: got %0b/%0d expected 1/3", out_valid, out_sel); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_data !== '0) $display("FAIL arst_data: got %0h expected 0", out_data); else n_pass++;
    n_total++; if (out_sel !== '0) $display("FAIL arst_sel: got %0d expected 0", out_sel); else n_pass++;
    for (int k = 0; k < NC; k++) set_ch(k, 32'h2000_0000 + k);
    in_valid = 4'b1111; out_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_total++; if (in_ready !== 4'b0000) $display("FAIL arst_release_ready: got %b expected 0000", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL arst_first_edge_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 4'b0001) $display("FAIL arst_grant0_ready: got %b expected 0001", in_ready); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'h2000_0000) $display("FAIL arst_grant0: got %0b/%0d/%0h expected 1/0/20000000", out_valid, out_sel, out_data); else n_pass++;
    in_valid = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [5:0]     seq[NC2];
    logic [NC2-1:0] acc;
    logic [7:0]     w;
    logic [7:0]     e;
    bit             gen;
    for (int k = 0; k < NC2; k++) seq[k] = '0;
    acc = '0;
    for (int cyc = 0; cyc < 10200; cyc++) begin
      @(negedge clk);
      gen = (cyc < 10000);
      r_in_valid = r_in_valid & ~acc;
      for (int k = 0; k < NC2; k++) begin
        if (!r_in_valid[k] && gen && ($urandom_range(1, 0) == 1)) begin
          w = {2'(k), seq[k]};
          seq[k] = seq[k] + 1'b1;
          r_in_data[k*DW2 +: DW2] = w;
          r_in_valid[k] = 1'b1;
          sb_q[k].push_back(w);
        end
      end
      r_out_ready = gen ? ($urandom_range(9, 0) < 7) : 1'b1;
      #4;
      n_total++;
      if ($countones(r_in_ready) > 1 || (r_in_ready & ~r_in_valid) != '0)
        $display("FAIL rnd_ready_onehot: got %b with valid %b", r_in_ready, r_in_valid);
      else n_pass++;
      if (r_out_valid && r_out_ready) begin
        n_total++;
        if (r_out_sel >= SW2'(NC2)) begin
          $display("FAIL rnd_sel_range: got %0d expected < %0d", r_out_sel, NC2);
        end else if (sb_q[r_out_sel].size() == 0) begin
          $display("FAIL rnd_dup: got %0h on ch %0d expected no word", r_out_data, r_out_sel);
        end else begin
          e = sb_q[r_out_sel].pop_front();
          if (r_out_data !== e) $display("FAIL rnd_order: got %0h expected %0h", r_out_data, e);
          else n_pass++;
        end
      end
      acc = r_in_valid & r_in_ready;
      @(posedge clk);
    end
    #1;
    for (int k = 0; k < NC2; k++) begin
      n_total++;
      if (sb_q[k].size() != 0) $display("FAIL rnd_lost: got %0d words left on ch %0d expected 0", sb_q[k].size(), k);
      else n_pass++;
    end
    n_total++;
    if (r_out_valid !== 1'b0 || r_in_valid != (r_in_valid & ~acc & r_in_valid) || (r_in_valid & ~acc) != '0)
      $display("FAIL rnd_drain: got valid %0b pending %b expected 0/000", r_out_valid, r_in_valid & ~acc);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = '0; out_ready = 1'b0;
    r_in_data = '0; r_in_valid = '0; r_out_ready = 1'b0;
    test_reset();
    test_single_ch2();
`ifdef MUX_ARB_RR_EN
    test_rr();
`else
    test_fixed();
`endif
    test_hold();
    test_reset_async();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
